// File: rtl/ecg_pkg.sv
// ============================================================================
//  Module   : ecg_pkg
//  Brief    : Shared types and frame constants for the ECG SPI ADC reader.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ecg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DATA_BITS  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_QUIET = 2'd3
  } state_t;

  // A frame is trusted only if the converter's leading zeros arrived intact.
  function automatic logic lead_ok(input logic [FRAME_BITS-1:0] frame);
    return frame[FRAME_BITS-1 -: LEAD_ZEROS] == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sclk_divider.sv
// ============================================================================
//  Module   : spi_sclk_divider
//  Brief    : SCLK half-period generator with rise/fall strobes; idles high.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi_sclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall,
  output logic o_pre_edge
);

  localparam int             c_cnt_w  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(CLK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_sclk;
  logic               w_edge;

  // Strobes mark the clk edge that will drive the next SCLK level.
  assign w_edge     = i_run && (r_cnt == '0);
  assign o_rise     = w_edge && !r_sclk;
  assign o_fall     = w_edge && r_sclk;
  assign o_pre_edge = i_run && (r_cnt == c_cnt_w'(1));
  assign o_sclk     = r_sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (!i_run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (w_edge) begin
      r_cnt  <= c_reload;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ecg_spi_adc_reader.sv
// ============================================================================
//  Module   : ecg_spi_adc_reader
//  Brief    : Fixed-rate SPI reader for a 12-bit serial ECG ADC (AD7476A class).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ecg_spi_adc_reader
  import ecg_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int QUIET_CYCLES  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic                        i_sdata,
  output logic                        o_csn,
  output logic                        o_sclk,
  output logic [DATA_BITS-1:0]        o_sample,
  output logic [DATA_BITS+LEAD_ZEROS-1:0] o_level,
  output logic                        o_sample_valid,
  output logic                        o_frame_error,
  output logic                        o_missed,
  output logic                        o_busy
);

  localparam int c_timer_w = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int c_bit_w   = $clog2(FRAME_BITS + 1);
  localparam int c_quiet_w = (QUIET_CYCLES > 2) ? $clog2(QUIET_CYCLES) : 1;
  localparam logic [c_timer_w-1:0] c_tick_val   = c_timer_w'(SAMPLE_PERIOD - 1);
  localparam logic [c_quiet_w-1:0] c_quiet_load = c_quiet_w'((QUIET_CYCLES > 0) ? QUIET_CYCLES - 1 : 0);

  if (CLK_DIV < 2) begin : g_chk_clk_div
    $error("ecg_spi_adc_reader: CLK_DIV must be at least 2");
  end
  if (SAMPLE_PERIOD <= 1 + 2 * FRAME_BITS * CLK_DIV + QUIET_CYCLES) begin : g_chk_period
    $error("ecg_spi_adc_reader: SAMPLE_PERIOD too short for one frame plus quiet time");
  end

  state_t                  r_state;
  logic [c_timer_w-1:0]    r_timer;
  logic [c_bit_w-1:0]      r_bit_cnt;
  logic [c_quiet_w-1:0]    r_quiet;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic [DATA_BITS-1:0]    r_sample;
  logic                    r_csn;
  logic                    r_sample_valid;
  logic                    r_frame_error;
  logic                    r_missed;
  logic                    r_busy;

  logic w_tick;
  logic w_run;
  logic w_sclk;
  logic w_rise;
  logic w_fall;
  logic w_pre_edge;

  assign w_tick = (r_timer == c_tick_val);
  assign w_run  = (r_state == ST_SHIFT);

  spi_sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_run),
    .o_sclk     (w_sclk),
    .o_rise     (w_rise),
    .o_fall     (w_fall),
    .o_pre_edge (w_pre_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_bit_cnt      <= '0;
      r_quiet        <= '0;
      r_shreg        <= '0;
      r_sample       <= '0;
      r_csn          <= 1'b1;
      r_sample_valid <= 1'b0;
      r_frame_error  <= 1'b0;
      r_missed       <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_frame_error  <= 1'b0;

      if (w_tick) begin
        r_timer <= '0;
        if (r_state != ST_IDLE) begin
          r_missed <= 1'b1;
        end
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_rise) begin
        r_shreg <= {r_shreg[FRAME_BITS-2:0], i_sdata};
      end

      case (r_state)
        ST_IDLE: begin
          if (w_tick && i_enable) begin
            r_state   <= ST_SHIFT;
            r_csn     <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          // Leave one cycle before the 17th fall would be driven, so CSn rises
          // exactly at the end of the last high phase.
          if ((r_bit_cnt == c_bit_w'(FRAME_BITS)) && w_pre_edge) begin
            r_state <= ST_DONE;
            r_csn   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (lead_ok(r_shreg)) begin
            r_sample       <= r_shreg[DATA_BITS-1:0];
            r_sample_valid <= 1'b1;
          end else begin
            r_frame_error  <= 1'b1;
          end
          if (QUIET_CYCLES == 0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_QUIET;
            r_quiet <= c_quiet_load;
          end
        end
        ST_QUIET: begin
          if (r_quiet == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_quiet <= r_quiet - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_csn   <= 1'b1;
        end
      endcase
    end
  end

  assign o_csn          = r_csn;
  assign o_sclk         = w_sclk;
  assign o_sample       = r_sample;
  assign o_level        = {r_sample, {LEAD_ZEROS{1'b0}}};
  assign o_sample_valid = r_sample_valid;
  assign o_frame_error  = r_frame_error;
  assign o_missed       = r_missed;
  assign o_busy         = r_busy;

endmodule

`default_nettype wire
